// File: rtl/pifo_reg_slots_pkg.sv
// Shared PIFO register definitions: default geometry and slot-field slicing helpers,
// used by the slot storage and by the downstream min-reduction tree.
package pifo_reg_slots_pkg;

    localparam int PIFO_REG_WIDTH  = 4;
    localparam int PIFO_IDX_WIDTH  = 2;
    localparam int PIFO_DATA_WIDTH = 8;
    localparam int PIFO_META_WIDTH = 16;

    // Lowest bit of slot i's field inside a flattened vector of w-bit fields.
    function automatic int slot_lsb(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/pifo_free_slot_enc.sv
// Lowest-free-slot priority encoder: picks the lowest set bit of free_mask.
module pifo_free_slot_enc #(
    parameter int REG_WIDTH = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [REG_WIDTH-1:0] free_mask,
    output logic [IDX_WIDTH-1:0] free_idx,
    output logic                 any_free
);

    // Scan from the top so the lowest free index wins.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = REG_WIDTH - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                free_idx = IDX_WIDTH'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pifo_reg_slots.sv
// PIFO register slot storage: inserts go to the lowest free slot, removals are by
// slot index. Exports flattened rank/index/valid vectors for the min-reduction tree.
//
// Handshakes: an insert is accepted on a cycle where ins_valid && ins_ready; ins_ready
// depends only on registered state. A removal is a single-cycle rem_req pulse; its result
// appears the following cycle as a one-cycle rem_valid (hit) or rem_err (empty slot) pulse.
module pifo_reg_slots
    import pifo_reg_slots_pkg::*;
#(
    parameter int REG_WIDTH  = PIFO_REG_WIDTH,
    parameter int IDX_WIDTH  = PIFO_IDX_WIDTH,
    parameter int DATA_WIDTH = PIFO_DATA_WIDTH,
    parameter int META_WIDTH = PIFO_META_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ins_valid,
    output logic                            ins_ready,
    input  logic [DATA_WIDTH-1:0]           ins_rank,
    input  logic [META_WIDTH-1:0]           ins_meta,
    input  logic                            rem_req,
    input  logic [IDX_WIDTH-1:0]            rem_idx,
    output logic                            rem_valid,
    output logic                            rem_err,
    output logic [DATA_WIDTH-1:0]           rem_rank,
    output logic [META_WIDTH-1:0]           rem_meta,
    output logic [REG_WIDTH*DATA_WIDTH-1:0] slot_data,
    output logic [REG_WIDTH*IDX_WIDTH-1:0]  slot_idx,
    output logic [REG_WIDTH-1:0]            slot_vld,
    output logic [IDX_WIDTH:0]              count,
    output logic                            full,
    output logic                            empty
);

    localparam logic [IDX_WIDTH:0] CNT_FULL = (IDX_WIDTH + 1)'(REG_WIDTH);
    localparam logic [IDX_WIDTH:0] CNT_ONE  = (IDX_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] rank_q [REG_WIDTH];
    logic [META_WIDTH-1:0] meta_q [REG_WIDTH];
    logic [REG_WIDTH-1:0]  vld_q;
    logic [REG_WIDTH-1:0]  vld_next;
    logic [IDX_WIDTH:0]    count_q;
    logic [IDX_WIDTH:0]    count_next;
    logic                  full_q;
    logic                  empty_q;
    logic                  rem_valid_q;
    logic                  rem_err_q;
    logic [DATA_WIDTH-1:0] rem_rank_q;
    logic [META_WIDTH-1:0] rem_meta_q;

    logic [IDX_WIDTH-1:0]  free_idx;
    logic                  any_free;
    logic                  accept;
    logic                  rem_hit;

    // Free slot is chosen from pre-edge valids, so a slot freed this cycle is not reused.
    pifo_free_slot_enc #(
        .REG_WIDTH(REG_WIDTH),
        .IDX_WIDTH(IDX_WIDTH)
    ) u_free_enc (
        .free_mask(~vld_q),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    assign ins_ready = ~full_q;
    assign accept    = ins_valid & ins_ready & any_free;
    assign rem_hit   = rem_req & vld_q[rem_idx];

    // Next occupancy: clear the removed slot, set the inserted one (never the same slot).
    always_comb begin
        vld_next = vld_q;
        if (rem_hit) vld_next[rem_idx] = 1'b0;
        if (accept)  vld_next[free_idx] = 1'b1;
    end

    // Occupancy count moves only when exactly one of insert/remove happens.
    always_comb begin
        count_next = count_q;
        if (accept && !rem_hit)      count_next = count_q + CNT_ONE;
        else if (!accept && rem_hit) count_next = count_q - CNT_ONE;
    end

    // Slot payload storage; removed slots keep stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_WIDTH; i++) begin
                rank_q[i] <= '0;
                meta_q[i] <= '0;
            end
        end else if (accept) begin
            rank_q[free_idx] <= ins_rank;
            meta_q[free_idx] <= ins_meta;
        end
    end

    // Occupancy vector, count and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            vld_q   <= vld_next;
            count_q <= count_next;
            full_q  <= (count_next == CNT_FULL);
            empty_q <= (count_next == '0);
        end
    end

    // Removal response: pulses for one cycle, rank/meta hold between hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_valid_q <= 1'b0;
            rem_err_q   <= 1'b0;
            rem_rank_q  <= '0;
            rem_meta_q  <= '0;
        end else begin
            rem_valid_q <= rem_hit;
            rem_err_q   <= rem_req & ~rem_hit;
            if (rem_hit) begin
                rem_rank_q <= rank_q[rem_idx];
                rem_meta_q <= meta_q[rem_idx];
            end
        end
    end

    // Flatten slot fields for the tree's first stage.
    for (genvar g = 0; g < REG_WIDTH; g++) begin : g_flat
        assign slot_data[slot_lsb(g, DATA_WIDTH) +: DATA_WIDTH] = rank_q[g];
        assign slot_idx[slot_lsb(g, IDX_WIDTH) +: IDX_WIDTH]    = IDX_WIDTH'(g);
    end

    assign slot_vld  = vld_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign rem_valid = rem_valid_q;
    assign rem_err   = rem_err_q;
    assign rem_rank  = rem_rank_q;
    assign rem_meta  = rem_meta_q;

    // Count can never grow past capacity because ins_ready gates inserts when full.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(accept && !rem_hit && count_q == CNT_FULL));

    // Registered full flag always agrees with the count.
    a_full_consistent: assert property (@(posedge clk) disable iff (rst)
        full_q == (count_q == CNT_FULL));

endmodule
